sort_actuator_scheduler: RTL and testbench
==========================================

// Module: sort_actuator_scheduler
// PURPOSE
//  N-channel sorting actuator scheduler sitting between the colour classifier/IR trigger logic and the diverter servos.
//  Each class event is queued per channel with a per-channel travel delay, so several objects can be in flight on the belt.
//  Each channel owns a servo FSM (move/hold/return, per-period ramp); one shared counter sets the PWM frame.
// PARAMETERS
//  NUM_CH     2          number of servo channels; class k (1..NUM_CH) drives channel k-1
//  CLS_W      2          width of evt_class
//  DEPTH      4          per-channel pending-event queue depth (power of 2, >=2)
//  TS_W       32         timestamp counter width; every DELAY must be < 2**(TS_W-1)
//  DELAY_VEC  {32'd500000000,32'd262500000}  packed NUM_CH x 32b travel delays in cycles; ch0 = LSBs
//  HOLD_CYC   30000000   cycles at TARGET_PULSE before return
//  PERIOD     2500000    PWM frame length in cycles (20 ms @125 MHz)
//  MIN_PULSE  62500      rest duty (cycles high)
//  TGT_PULSE  145833     actuated duty
//  STEP       250        duty change per PWM frame while ramping
// PORTS
//  clk        in   1                   system clock
//  rst_n      in   1                   synchronous, active-low reset
//  evt_valid  in   1                   one-cycle pulse: object passed trigger point
//  evt_class  in   CLS_W               class of that object; 0 or >NUM_CH = pass-through
//  manual     in   NUM_CH              per-channel immediate actuate request (level, sampled)
//  clr_err    in   1                   clears sticky ovf/late flags
//  pwm_out    out  NUM_CH              servo PWM, registered
//  busy       out  NUM_CH              channel FSM not IDLE
//  q_cnt      out  NUM_CH*($clog2(DEPTH)+1)  entries pending per channel
//  ovf        out  NUM_CH              sticky: event dropped, queue full
//  late       out  NUM_CH              sticky: head deadline matured while FSM not IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge)
//   - All queues emptied. All FSMs to IDLE. duty=MIN_PULSE. Timestamp and frame counter = 0.
//   - Output reset values: pwm_out=0, busy=0, q_cnt=0, ovf=0, late=0.
//   - A reset mid-move drops all pending events. The servo returns to rest on the first frame after reset.
//  Timestamp
//   - ts increments every cycle and wraps mod 2**TS_W.
//  Enqueue (valid class c)
//   - The event with class c is the one sampled with evt_valid at cycle t.
//   - It is written to channel c-1 as deadline = ts(t) + DELAY[c-1], mod 2**TS_W.
//   - q_cnt reflects the new entry at t+1.
//  Queue full
//   - If the queue is full and no pop occurs in the same cycle, the event is dropped and ovf[c-1] is set.
//   - If a pop occurs in the same cycle, both the push and the pop happen and q_cnt is unchanged.
//  Invalid or zero class
//   - The event is ignored silently.
//  Maturity
//   - The head is matured when (ts - head) mod 2**TS_W < 2**(TS_W-1). This is wrap-safe.
//  FSM per channel: IDLE -> MOVE -> HOLD -> RETURN -> IDLE
//   - IDLE: duty=MIN_PULSE.
//     - If the head is matured, pop the head and go to MOVE.
//     - Otherwise, if manual[i], go to MOVE; the queue is untouched.
//     - If both are true, the pop wins; manual is ignored that cycle.
//   - MOVE: at each frame start (frame counter==0), duty += STEP, clamped to TGT_PULSE. At duty==TGT_PULSE, go to HOLD and clear the hold timer.
//   - HOLD: count HOLD_CYC cycles, then go to RETURN.
//   - RETURN: at each frame start, duty -= STEP, clamped to MIN_PULSE. At duty==MIN_PULSE, go to IDLE.
//   - Events and manual requests arriving while not IDLE are not lost; they stay queued or are re-sampled.
//   - late[i] is set on any cycle where the head is matured and the FSM is not IDLE.
//  Latency
//   - With the FSM idle and DELAY=d, busy rises at cycle t+d+2.
//  PWM
//   - The frame counter runs 0..PERIOD-1.
//   - pwm_out[i] <= (frame_cnt < duty_i), one cycle of register latency.
//   - duty changes only at frame start, so there are no glitches inside a frame.
//  Errors
//   - clr_err clears ovf/late. A set and a clear in the same cycle resolve to set.
// TESTING
//  (sim params: NUM_CH=2, DEPTH=4, PERIOD=100, MIN=10, TGT=30, STEP=10, HOLD_CYC=50, DELAY={40,20})
//  T1 reset: hold rst_n=0 with evt_valid=1 and manual=2'b11 -> pwm_out, busy, q_cnt, ovf and late all stay 0; after release, pwm high 10 of 100 cycles.
//  T2 single: class 1 at t=0 -> busy[0] rises at t=22. Duty goes 20 then 30 on successive frames, holds 50 cycles, ramps 20 then 10. ch1 idle throughout.
//  T3 pipelined: class 2 at t=0, t=5, t=10 -> q_cnt[1] reads 1,2,3. The first fires at t=42. The 2nd and 3rd set late[1] and fire back-to-back after each RETURN.
//  T4 overflow: 5 class-1 events while ch0 is busy -> q_cnt=4, ovf[0]=1. clr_err clears it. Then simultaneous pop+push at full -> q_cnt stays 4, ovf stays 0.
//  T5 wrap: TS_W=8, event at ts=250 with DELAY 20 -> fires at ts=(270 mod 256)+2=16, not immediately.
//  T6 manual/pass-through: class 0 and class 3 -> no queue change. manual[1] pulse while idle -> busy[1] next cycle, q_cnt unchanged.

Source files
------------

// File: rtl/sort_actuator_scheduler.sv
// rtl/sort_actuator_scheduler.sv - per-channel delayed event queues driving ramped servo PWM FSMs
module sort_actuator_scheduler #(
  parameter int                    NUM_CH    = 2,
  parameter int                    CLS_W     = 2,
  parameter int                    DEPTH     = 4,
  parameter int                    TS_W      = 32,
  parameter logic [NUM_CH*32-1:0]  DELAY_VEC = {32'd500000000, 32'd262500000},
  parameter int                    HOLD_CYC  = 30000000,
  parameter int                    PERIOD    = 2500000,
  parameter int                    MIN_PULSE = 62500,
  parameter int                    TGT_PULSE = 145833,
  parameter int                    STEP      = 250
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  evt_valid,
  input  logic [CLS_W-1:0]                      evt_class,
  input  logic [NUM_CH-1:0]                     manual,
  input  logic                                  clr_err,
  output logic [NUM_CH-1:0]                     pwm_out,
  output logic [NUM_CH-1:0]                     busy,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   q_cnt,
  output logic [NUM_CH-1:0]                     ovf,
  output logic [NUM_CH-1:0]                     late
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RET  = 2'd3;

  localparam logic [31:0] MIN_D   = 32'(MIN_PULSE);
  localparam logic [31:0] TGT_D   = 32'(TGT_PULSE);
  localparam logic [31:0] STEP_D  = 32'(STEP);
  localparam logic [31:0] HOLD_M1 = 32'(HOLD_CYC - 1);
  localparam logic [31:0] PER_M1  = 32'(PERIOD - 1);

  logic [TS_W-1:0] ts;
  logic [31:0]     frame_cnt;
  logic            frame_start;

  assign frame_start = (frame_cnt == 32'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts        <= '0;
      frame_cnt <= '0;
    end else begin
      ts        <= ts + TS_W'(1);
      frame_cnt <= (frame_cnt == PER_M1) ? 32'd0 : frame_cnt + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [TS_W-1:0] DLY = TS_W'(DELAY_VEC[i*32 +: 32]);

    logic [TS_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic [1:0]      state;
    logic [31:0]     duty, hold_cnt;
    logic [TS_W-1:0] age;
    logic            mature_q, push, pop, full, empty, wr_en;
    logic            pwm_q, ovf_q, late_q;

    assign push  = evt_valid && (evt_class == CLS_W'(i + 1));
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign pop   = (state == ST_IDLE) && mature_q;
    assign wr_en = push && (!full || pop);
    assign age   = ts - mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= ts + DLY;
    end

    // Maturity is registered and forced low on a pop so the next head is judged fresh.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cnt      <= '0;
        mature_q <= 1'b0;
        ovf_q    <= 1'b0;
        late_q   <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        case ({wr_en, pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
        mature_q <= !pop && !empty && !age[TS_W-1];
        ovf_q    <= (push && full && !pop) || (ovf_q && !clr_err);
        late_q   <= (mature_q && state != ST_IDLE) || (late_q && !clr_err);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state    <= ST_IDLE;
        duty     <= MIN_D;
        hold_cnt <= '0;
        pwm_q    <= 1'b0;
      end else begin
        pwm_q <= (frame_cnt < duty);
        case (state)
          ST_IDLE: begin
            duty <= MIN_D;
            if (mature_q || manual[i]) state <= ST_MOVE;
          end
          ST_MOVE: begin
            if (duty == TGT_D) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end else if (frame_start) begin
              duty <= (duty + STEP_D >= TGT_D) ? TGT_D : duty + STEP_D;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == HOLD_M1) state <= ST_RET;
            else hold_cnt <= hold_cnt + 32'd1;
          end
          default: begin
            if (duty == MIN_D) state <= ST_IDLE;
            else if (frame_start) duty <= (duty < MIN_D + STEP_D) ? MIN_D : duty - STEP_D;
          end
        endcase
      end
    end

    assign pwm_out[i]          = pwm_q;
    assign busy[i]             = (state != ST_IDLE);
    assign q_cnt[i*CW +: CW]   = cnt;
    assign ovf[i]              = ovf_q;
    assign late[i]             = late_q;
  end

endmodule

// File: tb/tb_sort_actuator_scheduler.sv
// tb/tb_sort_actuator_scheduler.sv - directed bench for sort_actuator_scheduler
module tb_sort_actuator_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       evt_valid, clr_err;
  logic [1:0] evt_class, manual;
  logic [1:0] pwm_out, busy, ovf, late;
  logic [5:0] q_cnt;

  logic       evt_valid8, clr_err8;
  logic [1:0] evt_class8, manual8;
  logic [1:0] pwm8, busy8, ovf8, late8;
  logic [5:0] q_cnt8;

  int n_assert = 0;
  int n_fail   = 0;
  int now      = 0;
  bit released = 1'b0;
  int frame_hi0 [32];
  int frame_hi1 [32];

  always #5 clk = ~clk;

  sort_actuator_scheduler #(
    .NUM_CH(2), .CLS_W(2), .DEPTH(4), .TS_W(12),
    .DELAY_VEC({32'd40, 32'd20}), .HOLD_CYC(50), .PERIOD(100),
    .MIN_PULSE(10), .TGT_PULSE(30), .STEP(10)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_class(evt_class),
    .manual(manual), .clr_err(clr_err), .pwm_out(pwm_out), .busy(busy),
    .q_cnt(q_cnt), .ovf(ovf), .late(late)
  );

  // Narrow timestamp copy exercises wrap-around of the deadline compare.
  sort_actuator_scheduler #(
    .NUM_CH(2), .CLS_W(2), .DEPTH(4), .TS_W(8),
    .DELAY_VEC({32'd40, 32'd20}), .HOLD_CYC(50), .PERIOD(100),
    .MIN_PULSE(10), .TGT_PULSE(30), .STEP(10)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid8), .evt_class(evt_class8),
    .manual(manual8), .clr_err(clr_err8), .pwm_out(pwm8), .busy(busy8),
    .q_cnt(q_cnt8), .ovf(ovf8), .late(late8)
  );

  // pwm seen in cycle n reflects frame position n-1.
  always @(negedge clk) begin
    if (released && now >= 1 && (now - 1) / 100 < 32) begin
      frame_hi0[(now - 1) / 100] += int'(pwm_out[0]);
      frame_hi1[(now - 1) / 100] += int'(pwm_out[1]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, now, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic run_to(input int t);
    while (now < t) tick();
  endtask

  task automatic pulse_evt(input logic [1:0] cls);
    evt_valid = 1'b1;
    evt_class = cls;
    tick();
    evt_valid = 1'b0;
    evt_class = 2'd0;
  endtask

  initial begin
    rst_n = 1'b0; evt_valid = 1'b1; evt_class = 2'd1; manual = 2'b11; clr_err = 1'b0;
    evt_valid8 = 1'b1; evt_class8 = 2'd1; manual8 = 2'b11; clr_err8 = 1'b0;
    repeat (3) tick();
    chk("rst_pwm", 64'(pwm_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_qcnt", 64'(q_cnt), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_late", 64'(late), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);

    rst_n = 1'b1; evt_valid = 1'b0; evt_class = 2'd0; manual = 2'b00;
    evt_valid8 = 1'b0; evt_class8 = 2'd0; manual8 = 2'b00;
    now = 0;
    released = 1'b1;

    run_to(100);
    pulse_evt(2'd1);
    chk("t1_frame0_ch0", 64'(frame_hi0[0]), 64'd10);
    chk("t1_frame0_ch1", 64'(frame_hi1[0]), 64'd10);
    chk("t2_qcnt_push", 64'(q_cnt), 64'h01);
    run_to(121);
    chk("t2_busy_early", 64'(busy), 64'b00);
    run_to(122);
    chk("t2_busy_rise", 64'(busy), 64'b01);
    chk("t2_qcnt_pop", 64'(q_cnt), 64'h00);

    run_to(250);
    evt_valid8 = 1'b1; evt_class8 = 2'd1;
    tick();
    evt_valid8 = 1'b0; evt_class8 = 2'd0;
    chk("t5_q8", 64'(q_cnt8), 64'h01);
    run_to(253);
    chk("t5_not_immediate", 64'(busy8), 64'b00);
    run_to(271);
    chk("t5_busy_early", 64'(busy8), 64'b00);
    run_to(272);
    chk("t5_busy_rise", 64'(busy8), 64'b01);

    run_to(501);
    chk("t2_busy_ret", 64'(busy), 64'b01);
    run_to(502);
    chk("t2_busy_fall", 64'(busy), 64'b00);

    run_to(600);
    pulse_evt(2'd2);
    chk("t2_frame1", 64'(frame_hi0[1]), 64'd10);
    chk("t2_frame2", 64'(frame_hi0[2]), 64'd20);
    chk("t2_frame3", 64'(frame_hi0[3]), 64'd30);
    chk("t2_frame4", 64'(frame_hi0[4]), 64'd20);
    chk("t2_frame5", 64'(frame_hi0[5]), 64'd10);
    chk("t2_ch1_idle", 64'(frame_hi1[3]), 64'd10);
    chk("t3_qcnt1", 64'(q_cnt), 64'h08);
    run_to(605);
    pulse_evt(2'd2);
    chk("t3_qcnt2", 64'(q_cnt), 64'h10);
    run_to(610);
    pulse_evt(2'd2);
    chk("t3_qcnt3", 64'(q_cnt), 64'h18);
    run_to(641);
    chk("t3_busy_early", 64'(busy), 64'b00);
    run_to(642);
    chk("t3_busy_rise", 64'(busy), 64'b10);
    chk("t3_qcnt_pop1", 64'(q_cnt), 64'h10);
    run_to(646);
    chk("t3_late_early", 64'(late), 64'b00);
    run_to(647);
    chk("t3_late_set", 64'(late), 64'b10);

    run_to(1002);
    chk("t3_idle1", 64'(busy), 64'b00);
    chk("t3_qcnt_idle1", 64'(q_cnt), 64'h10);
    run_to(1003);
    chk("t3_fire2", 64'(busy), 64'b10);
    chk("t3_qcnt_pop2", 64'(q_cnt), 64'h08);
    run_to(1101);
    chk("t3_frame7", 64'(frame_hi1[7]), 64'd20);
    chk("t3_frame8", 64'(frame_hi1[8]), 64'd30);
    chk("t3_frame9", 64'(frame_hi1[9]), 64'd20);
    chk("t3_frame10", 64'(frame_hi1[10]), 64'd10);
    chk("t3_ch0_rest", 64'(frame_hi0[8]), 64'd10);
    run_to(1402);
    chk("t3_idle2", 64'(busy), 64'b00);
    run_to(1403);
    chk("t3_fire3", 64'(busy), 64'b10);
    chk("t3_qcnt_empty", 64'(q_cnt), 64'h00);
    run_to(1802);
    chk("t3_idle3", 64'(busy), 64'b00);

    run_to(1900);
    pulse_evt(2'd1);
    run_to(1922);
    chk("t4_busy", 64'(busy), 64'b01);
    run_to(1930);
    for (int k = 0; k < 5; k++) pulse_evt(2'd1);
    chk("t4_qcnt_full", 64'(q_cnt), 64'h04);
    chk("t4_ovf_set", 64'(ovf), 64'b01);
    run_to(1940);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_ovf_clr", 64'(ovf), 64'b00);
    chk("t4_late_clr", 64'(late), 64'b00);
    run_to(1951);
    chk("t4_late_early", 64'(late), 64'b00);
    run_to(1952);
    chk("t4_late_set", 64'(late), 64'b01);
    run_to(2302);
    chk("t4_idle", 64'(busy), 64'b00);
    chk("t4_qcnt_before", 64'(q_cnt), 64'h04);
    pulse_evt(2'd1);
    chk("t4_pushpop_qcnt", 64'(q_cnt), 64'h04);
    chk("t4_pushpop_ovf", 64'(ovf), 64'b00);
    chk("t4_pushpop_busy", 64'(busy), 64'b01);

    run_to(2400);
    pulse_evt(2'd0);
    chk("t6_class0", 64'(q_cnt), 64'h04);
    pulse_evt(2'd3);
    chk("t6_class3", 64'(q_cnt), 64'h04);
    chk("t6_class3_ovf", 64'(ovf), 64'b00);
    run_to(2410);
    chk("t6_pre_manual", 64'(busy), 64'b01);
    manual = 2'b10;
    tick();
    manual = 2'b00;
    chk("t6_manual_busy", 64'(busy), 64'b11);
    chk("t6_manual_qcnt", 64'(q_cnt), 64'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
